// File: rtl/operator_frame_scheduler_pkg.sv
// ============================================================================
// Module : operator_frame_scheduler_pkg
// Brief  : Shared types for the operator frame scheduler and its config FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package operator_frame_scheduler_pkg;

`ifndef NUM_VOICE_OPERATORS
`define NUM_VOICE_OPERATORS 8
`endif

    localparam int NUM_VOICE_OPS = `NUM_VOICE_OPERATORS;

    // Counter/pointer width helper that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int OP_ID_W = clog2_min1(NUM_VOICE_OPS);

    typedef logic [OP_ID_W-1:0] VoiceOperatorID_t;

    typedef struct packed {
        VoiceOperatorID_t Addr;
        logic [1:0]       ByteSel;
        logic [7:0]       Data;
    } AlgoCfgWrite_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_DRAIN = 2'd3
    } FrameSchedState_t;

endpackage

`default_nettype wire

// File: rtl/operator_frame_scheduler_cfg_write_fifo.sv
// ============================================================================
// Module : cfg_write_fifo
// Brief  : Synchronous FIFO of algorithm config writes with a look-ahead head.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cfg_write_fifo
    import operator_frame_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  AlgoCfgWrite_t push_data,
    input  logic          pop,
    output logic          head_valid,
    output AlgoCfgWrite_t head_data,
    output logic          full
);

    localparam int AW = clog2_min1(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    AlgoCfgWrite_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push && !full;

    // The head looks one edge ahead: an entry arriving now is what the
    // registered consumer will present next cycle, never this cycle.
    assign head_valid = !empty || push_ok;
    assign head_data  = empty ? push_data : mem[rd_ptr];
    assign pop_ok     = pop && head_valid;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/operator_frame_scheduler.sv
// ============================================================================
// Module : operator_frame_scheduler
// Brief  : Issues operator IDs per sample tick, then drains buffered algorithm
//          writes in a post-frame window. Option: SEQ_OVERRUN_FLAG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module operator_frame_scheduler
    import operator_frame_scheduler_pkg::*;
#(
    parameter int NUM_OPS      = NUM_VOICE_OPS,
    parameter int FIFO_DEPTH   = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_WR_FRAME = 4
)(
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_SampleTick,
    output logic             o_OperatorValid,
    output VoiceOperatorID_t o_VoiceOperator,
    output logic             o_FrameDone,
    input  logic             i_CfgValid,
    output logic             o_CfgReady,
    input  VoiceOperatorID_t i_CfgAddr,
    input  logic [1:0]       i_CfgByteSel,
    input  logic [7:0]       i_CfgData,
    output logic [1:0]       o_AlgorithmWriteEnable,
    output VoiceOperatorID_t o_AlgorithmWriteAddr,
    output logic [7:0]       o_AlgorithmWriteData
`ifdef SEQ_OVERRUN_FLAG_EN
    ,
    output logic             o_Overrun,
    output logic [7:0]       o_OverrunCount
`endif
);

    localparam int GW = clog2_min1(GUARD_CYCLES);
    localparam int DW = clog2_min1(MAX_WR_FRAME + 1);
    localparam VoiceOperatorID_t LAST_OP    = VoiceOperatorID_t'(NUM_OPS - 1);
    localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [DW-1:0]    DRAIN_MAX  = DW'(MAX_WR_FRAME);

    FrameSchedState_t state;
    logic             pending;
    logic [GW-1:0]    guard_cnt;
    logic [DW-1:0]    drain_cnt;

    AlgoCfgWrite_t cfg_in;
    AlgoCfgWrite_t head;
    logic          head_valid;
    logic          fifo_full;
    logic          cfg_push;
    logic          fifo_pop;
    logic          guard_last;
    logic          drain_step;
    logic          drain_done;
    logic [DW-1:0] drain_base;
    logic          post_issue;
    logic          tick_defer;

    assign cfg_in     = '{Addr: i_CfgAddr, ByteSel: i_CfgByteSel, Data: i_CfgData};
    assign o_CfgReady = !fifo_full;
    assign cfg_push   = i_CfgValid && o_CfgReady;

    // A drain step decides, at the edge, what the next DRAIN cycle shows.
    // The final DRAIN cycle is the one carrying o_FrameDone.
    assign guard_last = (state == ST_GUARD) && (guard_cnt == GUARD_LAST);
    assign drain_step = guard_last || ((state == ST_DRAIN) && !o_FrameDone);
    assign drain_base = (state == ST_GUARD) ? '0 : drain_cnt;
    assign fifo_pop   = drain_step && head_valid;
    assign drain_done = !head_valid || ((drain_base + DW'(1)) == DRAIN_MAX);

    assign post_issue = (state == ST_GUARD) || (state == ST_DRAIN);
    assign tick_defer = i_SampleTick && post_issue && !pending;

    cfg_write_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_cfg_fifo (
        .clk        (i_Clock),
        .rst        (i_Reset),
        .push       (cfg_push),
        .push_data  (cfg_in),
        .pop        (fifo_pop),
        .head_valid (head_valid),
        .head_data  (head),
        .full       (fifo_full)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state                  <= ST_IDLE;
            pending                <= 1'b0;
            guard_cnt              <= '0;
            drain_cnt              <= '0;
            o_OperatorValid        <= 1'b0;
            o_VoiceOperator        <= '0;
            o_FrameDone            <= 1'b0;
            o_AlgorithmWriteEnable <= 2'b00;
            o_AlgorithmWriteAddr   <= '0;
            o_AlgorithmWriteData   <= 8'h00;
        end else begin
            o_OperatorValid        <= 1'b0;
            o_VoiceOperator        <= '0;
            o_FrameDone            <= 1'b0;
            o_AlgorithmWriteEnable <= 2'b00;
            o_AlgorithmWriteAddr   <= '0;
            o_AlgorithmWriteData   <= 8'h00;

            if (tick_defer) pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (i_SampleTick || pending) begin
                        state           <= ST_ISSUE;
                        o_OperatorValid <= 1'b1;
                        pending         <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (o_VoiceOperator == LAST_OP) begin
                        state     <= ST_GUARD;
                        guard_cnt <= '0;
                    end else begin
                        o_OperatorValid <= 1'b1;
                        o_VoiceOperator <= o_VoiceOperator + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (!guard_last) guard_cnt <= guard_cnt + 1'b1;
                end
                ST_DRAIN: begin
                    // A deferred tick (or one landing now) starts straight
                    // after the FrameDone cycle.
                    if (o_FrameDone) begin
                        if (pending || i_SampleTick) begin
                            state           <= ST_ISSUE;
                            o_OperatorValid <= 1'b1;
                            pending         <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (drain_step) begin
                state       <= ST_DRAIN;
                drain_cnt   <= fifo_pop ? (drain_base + DW'(1)) : drain_base;
                o_FrameDone <= drain_done;
                if (fifo_pop) begin
                    o_AlgorithmWriteEnable <= head.ByteSel;
                    o_AlgorithmWriteAddr   <= head.Addr;
                    o_AlgorithmWriteData   <= head.Data;
                end
            end
        end
    end

`ifdef SEQ_OVERRUN_FLAG_EN
    logic tick_dropped;

    assign tick_dropped = i_SampleTick && ((state == ST_ISSUE) || (post_issue && pending));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Overrun      <= 1'b0;
            o_OverrunCount <= 8'h00;
        end else if (tick_dropped) begin
            o_Overrun <= 1'b1;
            if (o_OverrunCount != 8'hFF) o_OverrunCount <= o_OverrunCount + 8'h01;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_operator_frame_scheduler.sv
// ============================================================================
// Module : tb_operator_frame_scheduler
// Brief  : Scoreboard bench with a frame-timeline reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_operator_frame_scheduler;
    import operator_frame_scheduler_pkg::*;

    localparam int NOPS  = 8;
    localparam int GUARD = 2;
    localparam int DEPTH = 4;
    localparam int MAXW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_SampleTick;
    logic             o_OperatorValid;
    VoiceOperatorID_t o_VoiceOperator;
    logic             o_FrameDone;
    logic             i_CfgValid;
    logic             o_CfgReady;
    VoiceOperatorID_t i_CfgAddr;
    logic [1:0]       i_CfgByteSel;
    logic [7:0]       i_CfgData;
    logic [1:0]       o_AlgorithmWriteEnable;
    VoiceOperatorID_t o_AlgorithmWriteAddr;
    logic [7:0]       o_AlgorithmWriteData;
`ifdef SEQ_OVERRUN_FLAG_EN
    logic             o_Overrun;
    logic [7:0]       o_OverrunCount;
`endif

    always #5 clk = ~clk;

    operator_frame_scheduler #(
        .NUM_OPS      (NOPS),
        .FIFO_DEPTH   (DEPTH),
        .GUARD_CYCLES (GUARD),
        .MAX_WR_FRAME (MAXW)
    ) dut (
        .i_Clock                (clk),
        .i_Reset                (rst),
        .i_SampleTick           (i_SampleTick),
        .o_OperatorValid        (o_OperatorValid),
        .o_VoiceOperator        (o_VoiceOperator),
        .o_FrameDone            (o_FrameDone),
        .i_CfgValid             (i_CfgValid),
        .o_CfgReady             (o_CfgReady),
        .i_CfgAddr              (i_CfgAddr),
        .i_CfgByteSel           (i_CfgByteSel),
        .i_CfgData              (i_CfgData),
        .o_AlgorithmWriteEnable (o_AlgorithmWriteEnable),
        .o_AlgorithmWriteAddr   (o_AlgorithmWriteAddr),
        .o_AlgorithmWriteData   (o_AlgorithmWriteData)
`ifdef SEQ_OVERRUN_FLAG_EN
        ,
        .o_Overrun              (o_Overrun),
        .o_OverrunCount         (o_OverrunCount)
`endif
    );

    typedef struct {
        int               c;
        VoiceOperatorID_t addr;
        logic [1:0]       sel;
        logic [7:0]       data;
    } ent_t;

    typedef struct {
        int               c;
        VoiceOperatorID_t id;
    } iss_t;

    // Reference model: frame timeline derived from the start cycle of each frame.
    ent_t m_fifo[$];
    ent_t host_q[$];
    ent_t wr_q[$];
    iss_t issue_q[$];
    int   done_q[$];
    bit   m_active;
    bit   m_pend;
    int   m_fs;
    int   m_pops;
    int   m_drops;
    bit   host_gaps;

    int   cyc;
    int   pass_cnt;
    int   total_cnt;

    iss_t mi;
    ent_t mw;
    int   md;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({o_OperatorValid, o_VoiceOperator, o_FrameDone, o_AlgorithmWriteEnable,
                         o_AlgorithmWriteAddr, o_AlgorithmWriteData}), 32'd0);
    endtask

`ifdef SEQ_OVERRUN_FLAG_EN
    task automatic check_overrun();
        check("overrun_flag", o_Overrun, (m_drops > 0) ? 1 : 0);
        check("overrun_count", o_OverrunCount, (m_drops > 255) ? 255 : m_drops);
    endtask
`endif

    task automatic step(input bit tick);
        bit   ended;
        bit   rdy;
        bit   cv;
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        ended = 1'b0;
        if (m_active) begin
            if (cyc < m_fs + NOPS) begin
                issue_q.push_back('{c: cyc, id: VoiceOperatorID_t'(cyc - m_fs)});
            end else if (cyc >= m_fs + NOPS + GUARD) begin
                if (m_fifo.size() > 0 && m_pops < MAXW) begin
                    e = m_fifo.pop_front();
                    m_pops++;
                    if (e.sel != 2'b00) wr_q.push_back('{c: cyc, addr: e.addr, sel: e.sel, data: e.data});
                    ended = (m_pops == MAXW);
                end else begin
                    ended = 1'b1;
                end
                if (ended) done_q.push_back(cyc);
            end
        end
        rdy = (m_fifo.size() < DEPTH);
        check("cfg_ready", o_CfgReady, rdy);
        if (ended) begin
            if (m_pend) begin
                m_fs   = cyc + 1;
                m_pops = 0;
                m_pend = 1'b0;
            end else begin
                m_active = 1'b0;
            end
        end
        if (tick) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_fs     = cyc + 1;
                m_pops   = 0;
            end else if (cyc < m_fs + NOPS || m_pend) begin
                m_drops++;
            end else begin
                m_pend = 1'b1;
            end
        end
        cv = (host_q.size() > 0) && (!host_gaps || $urandom_range(0, 3) != 0);
        i_SampleTick = tick;
        i_CfgValid   = cv;
        i_CfgAddr    = cv ? host_q[0].addr : '0;
        i_CfgByteSel = cv ? host_q[0].sel  : 2'b00;
        i_CfgData    = cv ? host_q[0].data : 8'h00;
        if (cv && rdy) begin
            e   = host_q.pop_front();
            e.c = cyc;
            m_fifo.push_back(e);
        end
    endtask

    task automatic apply_reset();
        issue_q.delete();
        wr_q.delete();
        done_q.delete();
        m_fifo.delete();
        host_q.delete();
        m_active = 1'b0;
        m_pend   = 1'b0;
        m_drops  = 0;
        i_SampleTick = 1'b0;
        i_CfgValid   = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("async_reset_outputs");
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
    endtask

    task automatic host_push(input int addr, input logic [1:0] sel, input logic [7:0] data);
        host_q.push_back('{c: 0, addr: VoiceOperatorID_t'(addr), sel: sel, data: data});
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_OperatorValid) begin
                if (issue_q.size() > 0) begin
                    mi = issue_q.pop_front();
                    check("issue_cycle", cyc, mi.c);
                    check("issue_id", o_VoiceOperator, mi.id);
                end else begin
                    check("issue_unexpected", o_OperatorValid, 0);
                end
            end
            while (issue_q.size() > 0 && issue_q[0].c < cyc) begin
                mi = issue_q.pop_front();
                check("issue_missing_cycle", cyc, mi.c);
            end
            if (o_AlgorithmWriteEnable != 2'b00) begin
                if (wr_q.size() > 0) begin
                    mw = wr_q.pop_front();
                    check("write_cycle", cyc, mw.c);
                    check("write_fields", {o_AlgorithmWriteEnable, o_AlgorithmWriteAddr, o_AlgorithmWriteData},
                          {mw.sel, mw.addr, mw.data});
                end else begin
                    check("write_unexpected", o_AlgorithmWriteEnable, 0);
                end
            end
            while (wr_q.size() > 0 && wr_q[0].c < cyc) begin
                mw = wr_q.pop_front();
                check("write_missing_cycle", cyc, mw.c);
            end
            if (o_FrameDone) begin
                if (done_q.size() > 0) begin
                    md = done_q.pop_front();
                    check("frame_done_cycle", cyc, md);
                end else begin
                    check("frame_done_unexpected", o_FrameDone, 0);
                end
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                md = done_q.pop_front();
                check("frame_done_missing_cycle", cyc, md);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        i_SampleTick = 1'b0;
        i_CfgValid   = 1'b0;
        i_CfgAddr    = '0;
        i_CfgByteSel = 2'b00;
        i_CfgData    = 8'h00;
        cyc = 0; pass_cnt = 0; total_cnt = 0;
        m_active = 1'b0; m_pend = 1'b0; m_fs = 0; m_pops = 0; m_drops = 0;
        host_gaps = 1'b0;
        #3;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame, tick at cycle 10, empty FIFO
        repeat (9) step(1'b0);
        step(1'b1);
        repeat (14) step(1'b0);

        // Write pushed during ISSUE lands in the first DRAIN cycle
        step(1'b1);
        step(1'b0);
        host_push(3, 2'b01, 8'h05);
        repeat (16) step(1'b0);

        // Six back-to-back writes: four per frame, rest next frame
        for (int i = 0; i < 6; i++) host_push(i, 2'(1 + (i % 3)), 8'(8'h10 + i));
        repeat (8) step(1'b0);
        step(1'b1);
        repeat (20) step(1'b0);
        step(1'b1);
        repeat (20) step(1'b0);

        // Tick in GUARD defers; tick in the following ISSUE is dropped
        step(1'b1);
        repeat (8) step(1'b0);
        step(1'b1);
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (15) step(1'b0);
`ifdef SEQ_OVERRUN_FLAG_EN
        check_overrun();
`endif

        // Reset at ID 4 with two writes queued
        host_push(1, 2'b11, 8'hA1);
        host_push(2, 2'b10, 8'hB2);
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (4) step(1'b0);
        @(posedge clk);
        #1;
        cyc++;
        check("pre_reset_id", {o_OperatorValid, o_VoiceOperator}, {1'b1, VoiceOperatorID_t'(4)});
        apply_reset();
`ifdef SEQ_OVERRUN_FLAG_EN
        check_overrun();
`endif
        step(1'b1);
        repeat (15) step(1'b0);

        // ByteSel 00 entry is consumed silently
        host_push(5, 2'b00, 8'hAA);
        repeat (2) step(1'b0);
        step(1'b1);
        repeat (14) step(1'b0);

        // Randomized traffic
        host_gaps = 1'b1;
        repeat (500) begin
            if ($urandom_range(0, 4) == 0)
                host_push(int'($urandom_range(0, NOPS - 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            step($urandom_range(0, 11) == 0);
        end
`ifdef SEQ_OVERRUN_FLAG_EN
        check_overrun();
`endif

        // Bounded flush of everything still in flight
        for (int k = 0; k < 200; k++) begin
            if (!m_active && host_q.size() == 0 && issue_q.size() == 0 &&
                wr_q.size() == 0 && done_q.size() == 0) break;
            step(1'b0);
        end
        @(negedge clk);
        #1;
        check("leftover_events", 32'(issue_q.size() + wr_q.size() + done_q.size() + host_q.size()
                                    + (m_active ? 1 : 0)), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
